// File: rtl/sprite_mixer_pkg.sv
// Shared types and constants for the sprite mixer: game state, colour and
// the priority-select result.
package sprite_mixer_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t BG_RGB_DEFAULT = 24'h000000;

  // Wide enough to index the largest legal layer count (8).
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    PLAY,
    DEAD,
    FINISHED
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } prio_t;

endpackage

// File: rtl/sprite_mixer_edge_detect_rise.sv
// 1-bit synchronous rising-edge detector with a registered one-cycle pulse.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev;

  // Keep one cycle of history and flag the 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      // NOTE: non-blocking, so rise compares against prev's pre-edge value.
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/sprite_mixer.sv
// Sprite layer mixer: two-stage priority colour pipeline plus the
// collision/goal game-state machine evaluated at each frame start.
module sprite_mixer
  import sprite_mixer_pkg::*;
#(
  parameter int   NUM_LAYERS = 4,
  parameter rgb_t BG_RGB     = BG_RGB_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_de,
  input  logic                     i_v_sync,
  input  logic [NUM_LAYERS-1:0]    i_layer_hit,
  input  logic [NUM_LAYERS*24-1:0] i_layer_rgb,
  input  logic                     i_restart,
  output logic                     o_de,
  output logic [23:0]              o_rgb,
  output logic                     o_is_dead,
  output logic                     o_is_finished,
  output logic                     o_frame_start
);

  // Lowest-index layer with its hit bit set wins.
  function automatic prio_t prio_sel(input logic [NUM_LAYERS-1:0] hit);
    prio_t res;
    res = '{hit: 1'b0, idx: '0};
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        res.hit = 1'b1;
        res.idx = IDX_W'(i);
      end
    end
    return res;
  endfunction

  prio_t  sel;
  rgb_t   sel_rgb;
  logic   de_s1;
  logic   hit_s1;
  rgb_t   rgb_s1;
  logic   collide;
  logic   goal;
  state_t state;
  logic   pend_dead;
  logic   pend_goal;

  // Pick the winning layer's colour; only a hit layer's colour is ever
  // routed, so undriven colours on other layers cannot leak through.
  always_comb begin
    // NOTE: default first so every path assigns sel_rgb and no latch forms.
    sel_rgb = '0;
    sel     = prio_sel(i_layer_hit);
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (sel.hit && sel.idx == IDX_W'(i)) sel_rgb = i_layer_rgb[i*24 +: 24];
    end
  end

  // Stage 1: register display-enable and the priority-selected colour.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      de_s1  <= 1'b0;
      hit_s1 <= 1'b0;
      rgb_s1 <= '0;
    end else begin
      de_s1  <= i_de;
      hit_s1 <= sel.hit;
      rgb_s1 <= sel_rgb;
    end
  end

  // Stage 2: final colour, background when nothing hit, black when blanked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_de  <= 1'b0;
      o_rgb <= '0;
    end else begin
      o_de  <= de_s1;
      o_rgb <= !de_s1 ? 24'h000000 : (hit_s1 ? rgb_s1 : BG_RGB);
    end
  end

  assign collide = i_de & i_layer_hit[0] & (|i_layer_hit[NUM_LAYERS-2:1]);
  assign goal    = i_de & i_layer_hit[0] & i_layer_hit[NUM_LAYERS-1];

  edge_detect_rise u_vs_edge (
    .clk  (i_clk),
    .rst  (i_rst),
    .d    (i_v_sync),
    .rise (o_frame_start)
  );

  // Game FSM: accumulate events per frame, resolve them at frame start
  // (death beats goal), hold the end states until a restart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= PLAY;
      pend_dead     <= 1'b0;
      pend_goal     <= 1'b0;
      o_is_dead     <= 1'b0;
      o_is_finished <= 1'b0;
    end else if (i_restart) begin
      state         <= PLAY;
      pend_dead     <= 1'b0;
      pend_goal     <= 1'b0;
      o_is_dead     <= 1'b0;
      o_is_finished <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (o_frame_start) begin
            if (pend_dead) begin
              state     <= DEAD;
              o_is_dead <= 1'b1;
              pend_dead <= 1'b0;
              pend_goal <= 1'b0;
            end else if (pend_goal) begin
              state         <= FINISHED;
              o_is_finished <= 1'b1;
              pend_dead     <= 1'b0;
              pend_goal     <= 1'b0;
            end else begin
              // Events on the frame-start cycle open the new frame.
              pend_dead <= collide;
              pend_goal <= goal;
            end
          end else begin
            pend_dead <= pend_dead | collide;
            pend_goal <= pend_goal | goal;
          end
        end
        default: begin
          // DEAD / FINISHED are absorbing; nothing accumulates here.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mixer.sv
// Self-checking bench for sprite_mixer: pixel results go through a
// scoreboard queue drained by a monitor; game-state results use check().
module tb_sprite_mixer;

  localparam int          NL = 4;
  localparam logic [23:0] BG = 24'h102030;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          de = 1'b0;
  logic          v_sync = 1'b0;
  logic          restart = 1'b0;
  logic [NL-1:0] hit = '0;
  logic [NL*24-1:0] lrgb = '0;

  logic          o_de;
  logic [23:0]   o_rgb;
  logic          o_is_dead;
  logic          o_is_finished;
  logic          o_frame_start;

  int            n_vec = 0;
  int            n_err = 0;
  logic [23:0]   sb[$];
  bit            blank_chk = 1'b0;

  sprite_mixer #(.NUM_LAYERS(NL), .BG_RGB(BG)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_de          (de),
    .i_v_sync      (v_sync),
    .i_layer_hit   (hit),
    .i_layer_rgb   (lrgb),
    .i_restart     (restart),
    .o_de          (o_de),
    .o_rgb         (o_rgb),
    .o_is_dead     (o_is_dead),
    .o_is_finished (o_is_finished),
    .o_frame_start (o_frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented pixel must match the oldest expected entry;
  // blanked output must be black.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_de) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pixel: got rgb %h, expected no pixel", o_rgb);
        end else begin
          check("pixel_rgb", {8'h00, o_rgb}, {8'h00, sb.pop_front()});
        end
      end else if (blank_chk) begin
        check("blank_rgb", {8'h00, o_rgb}, 32'h0);
      end
    end
  end

  task automatic pix(input logic d, input logic [3:0] h,
                     input logic [23:0] r3, input logic [23:0] r2,
                     input logic [23:0] r1, input logic [23:0] r0,
                     input bit push, input logic [23:0] exp);
    @(posedge clk); #1;
    de   = d;
    hit  = h;
    lrgb = {r3, r2, r1, r0};
    if (push) sb.push_back(exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      de   = 1'b0;
      hit  = '0;
      lrgb = '0;
    end
  endtask

  // Raise v_sync and return on the negedge where o_frame_start is high.
  task automatic frame_edge(input string tag);
    bit found;
    found = 1'b0;
    @(posedge clk); #1;
    v_sync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_frame_start) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_frame_start_seen"}, 32'(found), 32'd1);
    v_sync = 1'b0;
  endtask

  task automatic restart_pulse();
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic dead, input logic fin);
    check({tag, "_is_dead"}, 32'(o_is_dead), 32'(dead));
    check({tag, "_is_finished"}, 32'(o_is_finished), 32'(fin));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_o_de", 32'(o_de), 32'd0);
    check("rst_o_rgb", {8'h00, o_rgb}, 32'h0);
    check("rst_frame_start", 32'(o_frame_start), 32'd0);
    check_state("rst", 1'b0, 1'b0);
    blank_chk = 1'b1;

    // Pixel path: priority, background, blanking, X on non-hit layers.
    pix(1'b1, 4'b0110, 24'h111111, 24'h4F92B3, 24'h9AD2FF, 24'h222222, 1'b1, 24'h9AD2FF);
    pix(1'b1, 4'b0000, 24'h333333, 24'h444444, 24'h555555, 24'h666666, 1'b1, BG);
    pix(1'b0, 4'b0001, 24'h0, 24'h0, 24'h0, 24'hFF00FF, 1'b0, 24'h0);
    pix(1'b1, 4'b1000, 24'hABCDEF, 24'h010101, 24'h020202, 24'h030303, 1'b1, 24'hABCDEF);
    pix(1'b1, 4'b1111, 24'h999999, 24'h888888, 24'h777777, 24'h112233, 1'b1, 24'h112233);
    pix(1'b1, 4'b0100, 24'hxxxxxx, 24'h445566, 24'hxxxxxx, 24'hxxxxxx, 1'b1, 24'h445566);
    pix(1'b1, 4'b0000, 24'hxxxxxx, 24'hxxxxxx, 24'hxxxxxx, 24'hxxxxxx, 1'b1, BG);
    pix(1'b1, 4'b1010, 24'h777777, 24'h888888, 24'h5A5A5A, 24'hxxxxxx, 1'b1, 24'h5A5A5A);
    idle(4);
    check("pixel_drain", 32'(sb.size()), 32'd0);

    // The 4'b1111 pixel left a collision pending; restart in PLAY drops it.
    restart_pulse();
    @(negedge clk);
    check_state("restart_play", 1'b0, 1'b0);
    idle(2);
    frame_edge("clr");
    @(negedge clk);
    check_state("clr", 1'b0, 1'b0);
    check("clr_pulse_width", 32'(o_frame_start), 32'd0);

    // Death resolves only at frame start, then holds.
    pix(1'b1, 4'b0011, 24'h0, 24'h0, 24'h00AA00, 24'hFF0000, 1'b1, 24'hFF0000);
    idle(3);
    @(negedge clk);
    check_state("dead_before_vsync", 1'b0, 1'b0);
    frame_edge("death");
    check_state("death_during_fs", 1'b0, 1'b0);
    @(negedge clk);
    check_state("death_after_fs", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(2);
      frame_edge("hold");
      @(negedge clk);
      check_state("dead_hold", 1'b1, 1'b0);
    end

    // Restart leaves DEAD exactly one cycle later.
    @(posedge clk); #1;
    restart = 1'b1;
    @(negedge clk);
    check_state("restart_same_cycle", 1'b1, 1'b0);
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    check_state("restart_next_cycle", 1'b0, 1'b0);

    // Collision and goal in the same frame: death wins.
    pix(1'b1, 4'b1011, 24'h0000AA, 24'h0, 24'h0000BB, 24'h00FF00, 1'b1, 24'h00FF00);
    idle(2);
    frame_edge("both");
    @(negedge clk);
    check_state("both", 1'b1, 1'b0);
    restart_pulse();
    @(negedge clk);
    check_state("both_restart", 1'b0, 1'b0);

    // Goal only.
    pix(1'b1, 4'b1001, 24'h00CC00, 24'h0, 24'h0, 24'h0000FF, 1'b1, 24'h0000FF);
    idle(2);
    frame_edge("goal");
    @(negedge clk);
    check_state("goal", 1'b0, 1'b1);
    restart_pulse();
    @(negedge clk);
    check_state("goal_restart", 1'b0, 1'b0);

    // Collision on the frame-start cycle belongs to the next frame.
    idle(2);
    frame_edge("coin");
    de   = 1'b1;
    hit  = 4'b0011;
    lrgb = {24'h0, 24'h0, 24'h0, 24'hCCCCCC};
    sb.push_back(24'hCCCCCC);
    idle(1);
    @(negedge clk);
    check_state("coin_not_yet", 1'b0, 1'b0);
    idle(2);
    frame_edge("coin2");
    @(negedge clk);
    check_state("coin_next_frame", 1'b1, 1'b0);
    restart_pulse();

    // Restart coincident with frame start while a goal is pending.
    pix(1'b1, 4'b1001, 24'h00CC00, 24'h0, 24'h0, 24'h0000FF, 1'b1, 24'h0000FF);
    idle(2);
    frame_edge("rvf");
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    @(negedge clk);
    check_state("restart_vs_fs", 1'b0, 1'b0);
    idle(2);
    frame_edge("rvf2");
    @(negedge clk);
    check_state("restart_vs_fs_next", 1'b0, 1'b0);

    // Reset while DEAD with pixels in flight: nothing of them emerges.
    pix(1'b1, 4'b0011, 24'h0, 24'h0, 24'h0, 24'hFF0000, 1'b1, 24'hFF0000);
    idle(2);
    frame_edge("pre_rst");
    @(negedge clk);
    check_state("pre_rst", 1'b1, 1'b0);
    idle(3);
    pix(1'b1, 4'b0001, 24'h0, 24'h0, 24'h0, 24'hEEEEEE, 1'b0, 24'h0);
    @(posedge clk); #1;
    rst  = 1'b1;
    hit  = 4'b0010;
    lrgb = {24'h0, 24'h0, 24'hDDDDDD, 24'h0};
    @(posedge clk); #1;
    rst = 1'b0;
    de  = 1'b0;
    hit = '0;
    lrgb = '0;
    @(negedge clk);
    check("midrst_o_de", 32'(o_de), 32'd0);
    check("midrst_o_rgb", {8'h00, o_rgb}, 32'h0);
    check("midrst_frame_start", 32'(o_frame_start), 32'd0);
    check_state("midrst", 1'b0, 1'b0);
    idle(4);
    check("final_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected the sequence to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
